// File: rtl/oric_tap_pkg.sv
// -----------------------------------------------------------------------------
// oric_tap_pkg
// Shared definitions for the Oric cassette recorder:
//   - tap_state_e   : decoder FSM state encoding
//   - T_ONE_MAX_DEF : default max period (ce ticks) decoded as bit '1'
//   - T_ZERO_MAX_DEF: default max period decoded as bit '0' (at/above = gap)
//   - CNT_W         : width of the saturating period counter
//   - parity_ok()   : odd-parity test over data + parity bit
// -----------------------------------------------------------------------------
package oric_tap_pkg;

    localparam int unsigned T_ONE_MAX_DEF  = 312;
    localparam int unsigned T_ZERO_MAX_DEF = 1000;
    localparam int unsigned CNT_W          = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tap_state_e;

    // Odd parity: the data bits together with the parity bit hold an odd
    // number of ones.
    function automatic logic parity_ok(input logic [7:0] data, input logic pbit);
        return ^{data, pbit};
    endfunction

endpackage

// File: rtl/oric_tap_fifo.sv
// -----------------------------------------------------------------------------
// oric_tap_fifo
// Synchronous FIFO for decoded bytes, registered occupancy count.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   push, wdata  : write request and data (ignored when full unless popping)
//   pop, rdata   : read request (ignored when empty), head-of-queue data
//   full, empty  : occupancy flags derived from the registered count
// A push into a full FIFO succeeds when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module oric_tap_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/oric_tap_recorder.sv
// -----------------------------------------------------------------------------
// oric_tap_recorder
// Decodes the Oric cassette output (pulse-period coding) into bytes and
// writes them to memory at consecutive addresses through a toggle handshake.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   ce            : 1 MHz timing enable (one clk wide)
//   record        : level; rising edge arms a capture, low stops it
//   tape_in       : asynchronous cassette signal
//   byte_req/ack  : write handshake toggles
//   byte_addr/out : write address / data
//   running       : capture armed
//   parity_err    : sticky bad parity since arm (TAP_PARITY_CHECK_EN only)
//   overflow      : sticky byte dropped (FIFO full or address space exhausted)
//   fsm_state     : decoder state, for observation
// Build option: define TAP_PARITY_CHECK_EN to check parity; otherwise the
// parity bit is consumed unchecked and parity_err is tied low.
// -----------------------------------------------------------------------------
module oric_tap_recorder
    import oric_tap_pkg::*;
#(
    parameter int unsigned T_ONE_MAX  = T_ONE_MAX_DEF,
    parameter int unsigned T_ZERO_MAX = T_ZERO_MAX_DEF,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              record,
    input  logic              tape_in,
    output logic              byte_req,
    input  logic              byte_ack,
    output logic [ADDR_W-1:0] byte_addr,
    output logic [7:0]        byte_out,
    output logic              running,
    output logic              parity_err,
    output logic              overflow,
    output tap_state_e        fsm_state
);

    localparam logic [CNT_W-1:0] ONE_LIM     = CNT_W'(T_ONE_MAX);
    localparam logic [CNT_W-1:0] ZERO_LIM    = CNT_W'(T_ZERO_MAX);
    localparam logic [CNT_W-1:0] ZERO_LIM_M1 = CNT_W'(T_ZERO_MAX - 1);

    // ---------------- edge detection and period measurement ----------------
    logic             tape_s1, tape_s2, tape_prev;
    logic [CNT_W-1:0] period_cnt;
    logic             tape_rise, timeout, bit_one, bit_zero, bit_valid, gap;

    assign tape_rise = tape_s2 && !tape_prev;
    // Fires once, on the tick that would take the counter to T_ZERO_MAX.
    assign timeout   = ce && !tape_rise && (period_cnt == ZERO_LIM_M1);
    assign bit_one   = tape_rise && (period_cnt < ONE_LIM);
    assign bit_zero  = tape_rise && (period_cnt >= ONE_LIM) && (period_cnt < ZERO_LIM);
    assign bit_valid = bit_one || bit_zero;
    assign gap       = (tape_rise && (period_cnt >= ZERO_LIM)) || timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tape_s1    <= 1'b0;
            tape_s2    <= 1'b0;
            tape_prev  <= 1'b0;
            period_cnt <= '0;
        end else begin
            tape_s1   <= tape_in;
            tape_s2   <= tape_s1;
            tape_prev <= tape_s2;
            // A tick coinciding with the edge belongs to the new period.
            if (tape_rise)                 period_cnt <= CNT_W'(ce);
            else if (ce && !(&period_cnt)) period_cnt <= period_cnt + 1'b1;
        end
    end

    // ---------------- decoder FSM ----------------
    tap_state_e state, state_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [2:0] one_cnt, one_cnt_n;
    logic [7:0] shreg, shreg_n;
    logic       record_prev;
    logic       arm, push_byte;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            bit_idx     <= '0;
            one_cnt     <= '0;
            shreg       <= '0;
            record_prev <= 1'b0;
        end else begin
            state       <= state_n;
            bit_idx     <= bit_idx_n;
            one_cnt     <= one_cnt_n;
            shreg       <= shreg_n;
            record_prev <= record;
        end
    end

    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        one_cnt_n = (state == ST_SYNC) ? one_cnt : 3'd0;
        shreg_n   = shreg;
        arm       = 1'b0;
        push_byte = 1'b0;
        if (!record) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!record_prev) begin
                        state_n = ST_SYNC;
                        arm     = 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (bit_one) begin
                        if (one_cnt == 3'd7) state_n   = ST_START;
                        else                 one_cnt_n = one_cnt + 1'b1;
                    end else if (bit_zero || gap) begin
                        one_cnt_n = 3'd0;
                    end
                end
                ST_START: begin
                    if (gap) begin
                        state_n = ST_SYNC;
                    end else if (bit_zero) begin
                        state_n   = ST_DATA;
                        bit_idx_n = 3'd0;
                    end
                end
                ST_DATA: begin
                    if (gap) begin
                        state_n = ST_SYNC;
                    end else if (bit_valid) begin
                        shreg_n   = {bit_one, shreg[7:1]};
                        bit_idx_n = bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state_n = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (gap) begin
                        state_n = ST_SYNC;
                    end else if (bit_valid) begin
                        state_n   = ST_STOP;
                        push_byte = 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_one)               state_n = ST_START;
                    else if (bit_zero || gap)  state_n = ST_SYNC;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign running   = (state != ST_IDLE);
    assign fsm_state = state;

    // ---------------- byte FIFO and memory write port ----------------
    // Handshake: a write is outstanding while byte_req != byte_ack. The
    // recorder toggles byte_req to start a write and holds byte_out/byte_addr
    // until the arbiter toggles byte_ack back to match.
    logic       ack_q, ack_event, addr_last, addr_full, addr_blocked;
    logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic       issue, discard, drop;
    logic [7:0] fifo_rdata;

    assign ack_event    = (byte_ack != ack_q) && (byte_req != ack_q);
    assign addr_last    = &byte_addr;
    // Once the all-ones address has been written nothing more may be stored.
    assign addr_blocked = addr_full || (ack_event && addr_last);
    assign issue        = !fifo_empty && (byte_req == byte_ack) && !addr_blocked;
    assign discard      = !fifo_empty && addr_blocked;
    assign fifo_pop     = issue || discard;
    assign fifo_push    = push_byte && !addr_blocked;
    assign drop         = push_byte && (addr_blocked || (fifo_full && !fifo_pop));

    oric_tap_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wdata   (shreg),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_req  <= 1'b0;
            ack_q     <= 1'b0;
            byte_addr <= '0;
            byte_out  <= '0;
            addr_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            ack_q <= byte_ack;
            if (issue) begin
                byte_out <= fifo_rdata;
                byte_req <= ~byte_req;
            end
            if (arm) begin
                byte_addr <= '0;
                addr_full <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                if (ack_event) begin
                    if (addr_last) addr_full <= 1'b1;
                    else           byte_addr <= byte_addr + 1'b1;
                end
                if (drop || discard) overflow <= 1'b1;
            end
        end
    end

`ifdef TAP_PARITY_CHECK_EN
    logic par_err_q;
    logic par_bad;

    // At the parity edge shreg already holds all 8 data bits.
    assign par_bad = push_byte && !parity_ok(shreg, bit_one);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     par_err_q <= 1'b0;
        else if (arm)     par_err_q <= 1'b0;
        else if (par_bad) par_err_q <= 1'b1;
    end

    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_oric_tap_recorder.sv
// -----------------------------------------------------------------------------
// tb_oric_tap_recorder
// Self-checking bench: drives pulse-period coded bytes onto tape_in, plays the
// memory arbiter on byte_req/byte_ack and compares the observed writes with
// the bytes it sent (address = ordinal of the byte since arm, capacity of one
// outstanding write plus the FIFO when the arbiter stalls).
// -----------------------------------------------------------------------------
module tb_oric_tap_recorder;
    import oric_tap_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 24;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              ce;
    logic              record;
    logic              tape_in;
    logic              byte_req;
    logic              byte_ack;
    logic [ADDR_W-1:0] byte_addr;
    logic [7:0]        byte_out;
    logic              running;
    logic              parity_err;
    logic              overflow;
    tap_state_e        fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    // arbiter behaviour, set by the tests
    logic ack_hold  = 1'b0;
    int   ack_delay = 3;

    // scoreboard
    logic [7:0]        exp_q[$];
    logic [7:0]        obs_data_q[$];
    logic [ADDR_W-1:0] obs_addr_q[$];
    int                unstable_cnt = 0;

    oric_tap_recorder #(
        .T_ONE_MAX  (312),
        .T_ZERO_MAX (1000),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .record     (record),
        .tape_in    (tape_in),
        .byte_req   (byte_req),
        .byte_ack   (byte_ack),
        .byte_addr  (byte_addr),
        .byte_out   (byte_out),
        .running    (running),
        .parity_err (parity_err),
        .overflow   (overflow),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- arbiter model ----------------
    initial begin
        byte_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                byte_ack = 1'b0;
            end else if (!ack_hold && byte_req !== byte_ack) begin
                repeat (ack_delay) @(negedge clk);
                if (reset_n && !ack_hold && byte_req !== byte_ack) byte_ack = ~byte_ack;
            end
        end
    end

    // ---------------- write monitor ----------------
    initial begin
        logic              req_seen;
        logic [7:0]        hold_data;
        logic [ADDR_W-1:0] hold_addr;
        req_seen  = 1'b0;
        hold_data = '0;
        hold_addr = '0;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) begin
                req_seen = 1'b0;
            end else if (byte_req !== req_seen) begin
                req_seen  = byte_req;
                hold_data = byte_out;
                hold_addr = byte_addr;
                obs_data_q.push_back(byte_out);
                obs_addr_q.push_back(byte_addr);
            end else if (byte_req !== byte_ack &&
                         (byte_out !== hold_data || byte_addr !== hold_addr)) begin
                unstable_cnt++;
            end
        end
    end

    // ---------------- tape driver tasks ----------------
    // Tape is high on entry; the rising edge at the end of the call closes a
    // period of exactly p clocks (ce is high every clock, so p ticks).
    task automatic send_bit(input int p);
        repeat (p / 2) @(negedge clk);
        tape_in = 1'b0;
        repeat (p - p / 2) @(negedge clk);
        tape_in = 1'b1;
    endtask

    task automatic send_one();
        send_bit($urandom_range(150, 280));
    endtask

    task automatic send_zero();
        send_bit($urandom_range(330, 450));
    endtask

    task automatic send_leader(input int n);
        for (int i = 0; i < n; i++) send_one();
    endtask

    task automatic send_byte(input logic [7:0] d, input bit good_par);
        logic pbit;
        pbit = ~(^d);
        if (!good_par) pbit = ~pbit;
        send_zero();
        for (int i = 0; i < 8; i++) begin
            if (d[i]) send_one();
            else      send_zero();
        end
        if (pbit) send_one();
        else      send_zero();
        send_one();
    endtask

    task automatic arm();
        record = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        obs_data_q.delete();
        obs_addr_q.delete();
        record = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k;
        k = 0;
        while (obs_data_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        record  = 1'b0;
        tape_in = 1'b1;
        ce      = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (byte_req !== 1'b0) begin n_fail++; $display("FAIL reset_byte_req: got %b expected 0", byte_req); end
        n_checks++; if (byte_addr !== '0) begin n_fail++; $display("FAIL reset_byte_addr: got %0h expected 0", byte_addr); end
        n_checks++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL reset_byte_out: got %0h expected 0", byte_out); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, ST_IDLE); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_byte();
        ack_delay = 3;
        arm();
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL arm_running: got %b expected 1", running); end
        n_checks++; if (fsm_state !== ST_SYNC) begin n_fail++; $display("FAIL arm_state: got %0d expected %0d", fsm_state, ST_SYNC); end
        for (int i = 0; i < 16; i++) send_bit(208);
        send_byte(8'h55, 1'b1);
        exp_q.push_back(8'h55);
        wait_writes(1, 200);
        n_checks++; if (fsm_state !== ST_START) begin n_fail++; $display("FAIL single_state_after_stop: got %0d expected %0d", fsm_state, ST_START); end
        n_checks++; if (obs_data_q.size() != 1) begin n_fail++; $display("FAIL single_write_count: got %0d expected 1", obs_data_q.size()); end
        if (obs_data_q.size() >= 1) begin
            n_checks++; if (obs_data_q[0] !== 8'h55 || obs_addr_q[0] !== '0) begin n_fail++; $display("FAIL single_write: got data %0h addr %0h expected data 55 addr 0", obs_data_q[0], obs_addr_q[0]); end
        end
        n_checks++; if (byte_req !== 1'b1) begin n_fail++; $display("FAIL single_req_toggle: got %b expected 1", byte_req); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL single_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        ack_delay = 50;
        arm();
        send_leader(10);
        exp_q.push_back(8'h16);
        exp_q.push_back(8'h24);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < exp_q.size(); i++) begin
            d = exp_q[i];
            send_byte(d, 1'b1);
        end
        wait_writes(exp_q.size(), 500);
        n_checks++; if (obs_data_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_write_count: got %0d expected %0d", obs_data_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_data_q.size(); i++) begin
            n_checks++;
            if (obs_data_q[i] !== exp_q[i] || obs_addr_q[i] !== ADDR_W'(i)) begin
                n_fail++;
                $display("FAIL b2b_write[%0d]: got data %0h addr %0h expected data %0h addr %0h", i, obs_data_q[i], obs_addr_q[i], exp_q[i], i);
            end
        end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
        n_checks++; if (unstable_cnt != 0) begin n_fail++; $display("FAIL b2b_hold_stable: got %0d changes expected 0", unstable_cnt); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        int n_bytes;
        n_bytes   = FIFO_DEPTH + 2;
        ack_hold  = 1'b1;
        ack_delay = 4;
        arm();
        send_leader(10);
        for (int b = 0; b < n_bytes; b++) begin
            d = 8'($urandom_range(0, 255));
            send_byte(d, 1'b1);
            // one write in flight plus a full FIFO is all that fits
            if (b < 1 + FIFO_DEPTH) exp_q.push_back(d);
            if (b == FIFO_DEPTH) begin
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at_capacity: got %b expected 0", overflow); end
            end
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        n_checks++; if (obs_data_q.size() != 1) begin n_fail++; $display("FAIL ovf_held_writes: got %0d expected 1", obs_data_q.size()); end
        ack_hold = 1'b0;
        wait_writes(exp_q.size(), 400);
        n_checks++; if (obs_data_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_write_count: got %0d expected %0d", obs_data_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_data_q.size(); i++) begin
            n_checks++;
            if (obs_data_q[i] !== exp_q[i] || obs_addr_q[i] !== ADDR_W'(i)) begin
                n_fail++;
                $display("FAIL ovf_write[%0d]: got data %0h addr %0h expected data %0h addr %0h", i, obs_data_q[i], obs_addr_q[i], exp_q[i], i);
            end
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_parity();
        logic [7:0] d;
        logic       exp_err;
`ifdef TAP_PARITY_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        ack_delay = 3;
        arm();
        send_leader(10);
        d = 8'($urandom_range(0, 255));
        send_byte(d, 1'b1);
        exp_q.push_back(d);
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_good_byte: got %b expected 0", parity_err); end
        send_byte(8'h01, 1'b0);
        exp_q.push_back(8'h01);
        wait_writes(2, 200);
        n_checks++; if (parity_err !== exp_err) begin n_fail++; $display("FAIL parity_bad_byte: got %b expected %b", parity_err, exp_err); end
        n_checks++; if (obs_data_q.size() != 2) begin n_fail++; $display("FAIL parity_write_count: got %0d expected 2", obs_data_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_data_q.size(); i++) begin
            n_checks++;
            if (obs_data_q[i] !== exp_q[i] || obs_addr_q[i] !== ADDR_W'(i)) begin
                n_fail++;
                $display("FAIL parity_write[%0d]: got data %0h addr %0h expected data %0h addr %0h", i, obs_data_q[i], obs_addr_q[i], exp_q[i], i);
            end
        end
    endtask

    task automatic test_silence_and_stop();
        arm();
        send_leader(10);
        send_zero();
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1) send_one();
            else                           send_zero();
        end
        repeat (1200) @(negedge clk);
        n_checks++; if (fsm_state !== ST_SYNC) begin n_fail++; $display("FAIL silence_state: got %0d expected %0d", fsm_state, ST_SYNC); end
        n_checks++; if (obs_data_q.size() != 0) begin n_fail++; $display("FAIL silence_no_write: got %0d expected 0", obs_data_q.size()); end
        arm();
        send_leader(10);
        send_zero();
        for (int i = 0; i < 3; i++) send_one();
        record = 1'b0;
        @(negedge clk);
        n_checks++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL stop_state: got %0d expected %0d", fsm_state, ST_IDLE); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL stop_running: got %b expected 0", running); end
        repeat (20) @(negedge clk);
        n_checks++; if (obs_data_q.size() != 0) begin n_fail++; $display("FAIL stop_no_write: got %0d expected 0", obs_data_q.size()); end
    endtask

    task automatic test_period_boundaries();
        arm();
        // 311 is the longest '1'; exactly eight of them after the gap reach START
        for (int i = 0; i < 9; i++) send_bit(311);
        send_bit(312);              // start bit: shortest '0'
        send_bit(999);              // data 0xF0, LSB first, longest '0'
        send_bit(312);
        send_bit(999);
        send_bit(312);
        for (int i = 0; i < 4; i++) send_bit(311);
        send_bit(311);              // odd parity of 0xF0 is 1
        send_bit(311);              // stop
        exp_q.push_back(8'hF0);
        wait_writes(1, 200);
        n_checks++; if (obs_data_q.size() != 1) begin n_fail++; $display("FAIL boundary_write_count: got %0d expected 1", obs_data_q.size()); end
        if (obs_data_q.size() >= 1) begin
            n_checks++; if (obs_data_q[0] !== exp_q[0] || obs_addr_q[0] !== '0) begin n_fail++; $display("FAIL boundary_write: got data %0h addr %0h expected data %0h addr 0", obs_data_q[0], obs_addr_q[0], exp_q[0]); end
        end
    endtask

    task automatic test_reset_mid_write();
        int k;
        ack_hold = 1'b1;
        arm();
        send_leader(10);
        send_byte(8'hC3, 1'b1);
        k = 0;
        while (byte_req === byte_ack && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_checks++; if (byte_req === byte_ack || byte_out !== 8'hC3) begin n_fail++; $display("FAIL rst_pending_write: got req %b ack %b data %0h expected pending C3", byte_req, byte_ack, byte_out); end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (byte_req !== 1'b0) begin n_fail++; $display("FAIL rst_async_byte_req: got %b expected 0", byte_req); end
        n_checks++; if (byte_addr !== '0 || byte_out !== 8'h00) begin n_fail++; $display("FAIL rst_async_bus: got addr %0h data %0h expected 0 0", byte_addr, byte_out); end
        n_checks++; if (running !== 1'b0 || fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_async_fsm: got running %b state %0d expected 0 %0d", running, fsm_state, ST_IDLE); end
        n_checks++; if (overflow !== 1'b0 || parity_err !== 1'b0) begin n_fail++; $display("FAIL rst_async_flags: got ovf %b perr %b expected 0 0", overflow, parity_err); end
        record = 1'b0;
        @(negedge clk);
        reset_n  = 1'b1;
        ack_hold = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_parity();
        test_silence_and_stop();
        test_period_boundaries();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
